// File: rtl/sync_vg_cfg.sv
// +----------------------------------------------------------------------------+
// | sync_vg_cfg : reconfigurable progressive video timing generator with        |
// |               shadowed timing registers committed at frame boundaries.      |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_vg_cfg #(
  parameter int X_BITS         = 12,
  parameter int Y_BITS         = 12,
  parameter int OUT_LATENCY    = 1,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [X_BITS-1:0]         cfg_h_total,
  input  logic [X_BITS-1:0]         cfg_h_sync,
  input  logic [X_BITS-1:0]         cfg_h_bp,
  input  logic [X_BITS-1:0]         cfg_h_fp,
  input  logic [Y_BITS-1:0]         cfg_v_total,
  input  logic [Y_BITS-1:0]         cfg_v_sync,
  input  logic [Y_BITS-1:0]         cfg_v_bp,
  input  logic [Y_BITS-1:0]         cfg_v_fp,
  input  logic                      cfg_hs_pol,
  input  logic                      cfg_vs_pol,
  output logic                      cfg_err,
  output logic                      running,
  output logic                      hs_out,
  output logic                      vs_out,
  output logic                      de_out,
  output logic                      sof_out,
  output logic                      eol_out,
  output logic [X_BITS-1:0]         x_out,
  output logic [Y_BITS-1:0]         y_out,
  output logic [FRAME_CNT_BITS-1:0] frame_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  typedef struct packed {
    logic [X_BITS-1:0] h_total;
    logic [X_BITS-1:0] h_sync;
    logic [X_BITS-1:0] h_bp;
    logic [X_BITS-1:0] h_fp;
    logic [Y_BITS-1:0] v_total;
    logic [Y_BITS-1:0] v_sync;
    logic [Y_BITS-1:0] v_bp;
    logic [Y_BITS-1:0] v_fp;
    logic              hs_pol;
    logic              vs_pol;
  } timing_t;

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              de;
    logic              sof;
    logic              eol;
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
  } vid_t;

  logic [1:0]                state_q, state_d;
  timing_t                   act_q, act_d;
  timing_t                   shd_q, shd_d;
  logic [X_BITS-1:0]         h_count_q, h_count_d;
  logic [Y_BITS-1:0]         v_count_q, v_count_d;
  logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                      cfg_err_q, cfg_err_d;
  vid_t                      pipe_q [OUT_LATENCY];
  vid_t                      pipe_d [OUT_LATENCY];

  timing_t           cfg_word;
  logic [X_BITS+1:0] h_sum;
  logic [Y_BITS+1:0] v_sum;
  logic              cfg_ok;
  logic              xfer;
  logic              is_running;
  logic              h_last, v_last;
  logic [X_BITS-1:0] h_start, h_end;
  logic [Y_BITS-1:0] v_start, v_end;
  logic              hs_raw, vs_raw, de_raw;
  vid_t              term;

  assign cfg_word = '{h_total: cfg_h_total, h_sync: cfg_h_sync, h_bp: cfg_h_bp, h_fp: cfg_h_fp,
                      v_total: cfg_v_total, v_sync: cfg_v_sync, v_bp: cfg_v_bp, v_fp: cfg_v_fp,
                      hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

  // Porch sums are widened so that large field values cannot wrap past the total.
  assign h_sum  = {2'b00, cfg_h_sync} + {2'b00, cfg_h_bp} + {2'b00, cfg_h_fp};
  assign v_sum  = {2'b00, cfg_v_sync} + {2'b00, cfg_v_bp} + {2'b00, cfg_v_fp};
  assign cfg_ok = (cfg_h_total >= X_BITS'(2)) && (cfg_v_total != '0) &&
                  (h_sum < {2'b00, cfg_h_total}) && (v_sum < {2'b00, cfg_v_total});

  assign cfg_ready  = (state_q != ST_PEND);
  assign xfer       = cfg_valid && cfg_ready;
  assign is_running = (state_q != ST_IDLE);

  assign h_last = (h_count_q == act_q.h_total - X_BITS'(1));
  assign v_last = (v_count_q == act_q.v_total - Y_BITS'(1));

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    shd_d       = shd_q;
    h_count_d   = h_count_q;
    v_count_d   = v_count_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = 1'b0;

    if (xfer) begin
      if (!cfg_ok) begin
        cfg_err_d = 1'b1;
      end else if (state_q == ST_IDLE) begin
        act_d   = cfg_word;
        state_d = ST_RUN;
      end else begin
        shd_d   = cfg_word;
        state_d = ST_PEND;
      end
    end

    if (is_running && enable) begin
      if (h_last) begin
        h_count_d = '0;
        if (v_last) begin
          v_count_d   = '0;
          frame_cnt_d = frame_cnt_q + FRAME_CNT_BITS'(1);
          if (state_q == ST_PEND) begin
            act_d   = shd_q;
            state_d = ST_RUN;
          end
        end else begin
          v_count_d = v_count_q + Y_BITS'(1);
        end
      end else begin
        h_count_d = h_count_q + X_BITS'(1);
      end
    end
  end

  assign h_start = act_q.h_sync + act_q.h_bp;
  assign h_end   = act_q.h_total - act_q.h_fp - X_BITS'(1);
  assign v_start = act_q.v_sync + act_q.v_bp;
  assign v_end   = act_q.v_total - act_q.v_fp - Y_BITS'(1);

  assign hs_raw = (h_count_q < act_q.h_sync);
  assign vs_raw = (v_count_q < act_q.v_sync);
  assign de_raw = (h_count_q >= h_start) && (h_count_q <= h_end) &&
                  (v_count_q >= v_start) && (v_count_q <= v_end);

  // Polarity is applied before the delay line so a commit never misaligns sync and data.
  always_comb begin
    term = '0;
    if (is_running) begin
      term.hs  = hs_raw ~^ act_q.hs_pol;
      term.vs  = vs_raw ~^ act_q.vs_pol;
      term.de  = de_raw;
      term.x   = de_raw ? (h_count_q - h_start) : '0;
      term.y   = de_raw ? (v_count_q - v_start) : '0;
      term.sof = de_raw && (h_count_q == h_start) && (v_count_q == v_start);
      term.eol = de_raw && (h_count_q == h_end);
    end else begin
      term.hs  = ~act_q.hs_pol;
      term.vs  = ~act_q.vs_pol;
    end
  end

  always_comb begin
    pipe_d[0] = term;
    for (int i = 1; i < OUT_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      act_q         <= '0;
      act_q.hs_pol  <= 1'b1;
      act_q.vs_pol  <= 1'b1;
      shd_q         <= '0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_cnt_q   <= '0;
      cfg_err_q     <= 1'b0;
      for (int i = 0; i < OUT_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      h_count_q   <= h_count_d;
      v_count_q   <= v_count_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_err_q   <= cfg_err_d;
      if (enable) begin
        for (int i = 0; i < OUT_LATENCY; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end
  end

  assign cfg_err     = cfg_err_q;
  assign running     = is_running;
  assign frame_count = frame_cnt_q;
  assign hs_out      = pipe_q[OUT_LATENCY-1].hs;
  assign vs_out      = pipe_q[OUT_LATENCY-1].vs;
  assign de_out      = pipe_q[OUT_LATENCY-1].de;
  assign sof_out     = pipe_q[OUT_LATENCY-1].sof;
  assign eol_out     = pipe_q[OUT_LATENCY-1].eol;
  assign x_out       = pipe_q[OUT_LATENCY-1].x;
  assign y_out       = pipe_q[OUT_LATENCY-1].y;

endmodule

`default_nettype wire

// File: tb/tb_sync_vg_cfg.sv
// +----------------------------------------------------------------------------+
// | tb_sync_vg_cfg : directed, table-driven bench for sync_vg_cfg.              |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sync_vg_cfg;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [11:0] cfg_h_total = '0, cfg_h_sync = '0, cfg_h_bp = '0, cfg_h_fp = '0;
  logic [11:0] cfg_v_total = '0, cfg_v_sync = '0, cfg_v_bp = '0, cfg_v_fp = '0;
  logic        cfg_hs_pol = 1'b1, cfg_vs_pol = 1'b1;
  logic        cfg_err, running, hs_out, vs_out, de_out, sof_out, eol_out;
  logic [11:0] x_out, y_out;
  logic [1:0]  frame_count;

  int passed = 0;
  int total  = 0;
  int en_cyc = 0;

  sync_vg_cfg #(.X_BITS(12), .Y_BITS(12), .OUT_LATENCY(L), .FRAME_CNT_BITS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_fp(cfg_h_fp),
    .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_fp(cfg_v_fp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
    .cfg_err(cfg_err), .running(running),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .sof_out(sof_out), .eol_out(eol_out),
    .x_out(x_out), .y_out(y_out), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int n; int hs; int vs; int de; int sof; int eol; int x; int y;
  } vec_t;

  typedef struct {
    int ht; int hsy; int hbp; int hfp; int vt; int vsy; int vbp; int vfp; int err;
  } cfg_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] exp_pack(input int hs, input int vs, input int de,
                                           input int sof, input int eol, input int x, input int y);
    logic [11:0] xx, yy;
    xx = 12'(x);
    yy = 12'(y);
    return {3'b000, hs[0], vs[0], de[0], sof[0], eol[0], xx, yy};
  endfunction

  function automatic logic [31:0] act_pack();
    return {3'b000, hs_out, vs_out, de_out, sof_out, eol_out, x_out, y_out};
  endfunction

  task automatic tick();
    logic e;
    e = enable;
    @(posedge clk);
    #1;
    if (e) en_cyc++;
  endtask

  task automatic go_to(input int target);
    enable = 1'b1;
    while (en_cyc < target) tick();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    enable    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_cfg(input int ht, input int hsy, input int hbp, input int hfp,
                         input int vt, input int vsy, input int vbp, input int vfp,
                         input logic hp, input logic vp);
    cfg_h_total = 12'(ht);  cfg_h_sync = 12'(hsy); cfg_h_bp = 12'(hbp); cfg_h_fp = 12'(hfp);
    cfg_v_total = 12'(vt);  cfg_v_sync = 12'(vsy); cfg_v_bp = 12'(vbp); cfg_v_fp = 12'(vfp);
    cfg_hs_pol  = hp;       cfg_vs_pol = vp;
  endtask

  cfg_vec_t cv[10];
  vec_t     fv[12];

  initial begin
    int ptr, de_n, sof_n, eol_n;
    logic [31:0] frozen;

    // Validation cases: {h_total,h_sync,h_bp,h_fp, v_total,v_sync,v_bp,v_fp, expect_err}
    cv[0] = '{10, 2, 2, 1, 6, 1, 1, 1, 0};
    cv[1] = '{1, 0, 0, 0, 6, 1, 1, 1, 1};
    cv[2] = '{2, 0, 0, 1, 6, 1, 1, 1, 0};
    cv[3] = '{10, 4, 4, 2, 6, 1, 1, 1, 1};
    cv[4] = '{10, 4, 4, 1, 6, 1, 1, 1, 0};
    cv[5] = '{10, 2, 2, 1, 0, 0, 0, 0, 1};
    cv[6] = '{10, 2, 2, 1, 1, 0, 0, 0, 0};
    cv[7] = '{10, 2, 2, 1, 6, 2, 2, 2, 1};
    cv[8] = '{10, 4095, 2, 0, 6, 1, 1, 1, 1};
    cv[9] = '{10, 2, 2, 1, 6, 4094, 3, 0, 1};

    // First frame of 10x6 timing: {index=v*10+h, hs, vs, de, sof, eol, x, y}
    fv[0]  = '{0,  1, 1, 0, 0, 0, 0, 0};
    fv[1]  = '{1,  1, 1, 0, 0, 0, 0, 0};
    fv[2]  = '{2,  0, 1, 0, 0, 0, 0, 0};
    fv[3]  = '{13, 0, 0, 0, 0, 0, 0, 0};
    fv[4]  = '{24, 0, 0, 1, 1, 0, 0, 0};
    fv[5]  = '{25, 0, 0, 1, 0, 0, 1, 0};
    fv[6]  = '{28, 0, 0, 1, 0, 1, 4, 0};
    fv[7]  = '{29, 0, 0, 0, 0, 0, 0, 0};
    fv[8]  = '{34, 0, 0, 1, 0, 0, 0, 1};
    fv[9]  = '{48, 0, 0, 1, 0, 1, 4, 2};
    fv[10] = '{50, 1, 0, 0, 0, 0, 0, 0};
    fv[11] = '{59, 0, 0, 0, 0, 0, 0, 0};

    do_reset();
    chk("reset outputs", act_pack(), exp_pack(0, 0, 0, 0, 0, 0, 0));
    chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset running", 32'(running), 32'd0);
    chk("reset frame_count", 32'(frame_count), 32'd0);
    chk("reset cfg_err", 32'(cfg_err), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_cfg(cv[i].ht, cv[i].hsy, cv[i].hbp, cv[i].hfp, cv[i].vt, cv[i].vsy, cv[i].vbp, cv[i].vfp, 1'b1, 1'b1);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("validate[%0d] cfg_err", i), 32'(cfg_err), 32'(cv[i].err));
      chk($sformatf("validate[%0d] running", i), 32'(running), 32'(1 - cv[i].err));
      if (i == 1) begin
        chk("reject cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("cfg_err one-cycle pulse", 32'(cfg_err), 32'd0);
      end
    end

    // Main frame at 10x6, walked cycle by cycle.
    do_reset();
    set_cfg(10, 2, 2, 1, 6, 1, 1, 1, 1'b1, 1'b1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    en_cyc = 0;
    chk("idle->run running", 32'(running), 32'd1);
    ptr = 0; de_n = 0; sof_n = 0; eol_n = 0;
    while (en_cyc < L + 59) begin
      tick();
      if (en_cyc >= L) begin
        de_n  += int'(de_out);
        sof_n += int'(sof_out);
        eol_n += int'(eol_out);
      end
      if (ptr < 12 && fv[ptr].n + L == en_cyc) begin
        chk($sformatf("frame1 idx=%0d", fv[ptr].n), act_pack(),
            exp_pack(fv[ptr].hs, fv[ptr].vs, fv[ptr].de, fv[ptr].sof, fv[ptr].eol, fv[ptr].x, fv[ptr].y));
        ptr++;
      end
      if (en_cyc == 59) chk("frame_count before wrap", 32'(frame_count), 32'd0);
      if (en_cyc == 60) chk("frame_count after frame 1", 32'(frame_count), 32'd1);
    end
    chk("de pixels per frame", 32'(de_n), 32'd15);
    chk("sof per frame", 32'(sof_n), 32'd1);
    chk("eol per frame", 32'(eol_n), 32'd3);

    // Mid-frame reconfigure to a 12-pixel line with active-low hsync.
    go_to(75);
    set_cfg(12, 2, 2, 1, 6, 1, 1, 1, 1'b0, 1'b1);
    cfg_valid = 1'b1;
    tick();
    chk("pend cfg_ready low", 32'(cfg_ready), 32'd0);
    chk("pend running", 32'(running), 32'd1);
    set_cfg(1, 0, 0, 0, 6, 1, 1, 1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("held valid in pend no err %0d", i), 32'(cfg_err), 32'd0);
    end
    cfg_valid = 1'b0;
    go_to(119);
    chk("cfg_ready before commit", 32'(cfg_ready), 32'd0);
    go_to(120);
    chk("cfg_ready after commit", 32'(cfg_ready), 32'd1);
    chk("frame_count after frame 2", 32'(frame_count), 32'd2);
    go_to(121);
    chk("last old pixel", act_pack(), exp_pack(0, 0, 0, 0, 0, 0, 0));
    go_to(122);
    chk("new h=0 hs active-low", act_pack(), exp_pack(0, 1, 0, 0, 0, 0, 0));
    go_to(124);
    chk("new h=2 hs inactive", act_pack(), exp_pack(1, 1, 0, 0, 0, 0, 0));
    go_to(132);
    chk("new h=10 same line", act_pack(), exp_pack(1, 1, 0, 0, 0, 0, 0));
    go_to(134);
    chk("new line 1 h=0", act_pack(), exp_pack(0, 0, 0, 0, 0, 0, 0));
    go_to(150);
    chk("new frame sof", act_pack(), exp_pack(1, 0, 1, 1, 0, 0, 0));
    go_to(151);
    frozen = exp_pack(1, 0, 1, 0, 0, 1, 0);
    chk("pre-stall pixel", act_pack(), frozen);

    // Stall for 7 clocks mid-line.
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("stall hold %0d", i), act_pack(), frozen);
    end
    chk("stall frame_count hold", 32'(frame_count), 32'd2);
    go_to(152);
    chk("resume next pixel", act_pack(), exp_pack(1, 0, 1, 0, 0, 2, 0));
    go_to(156);
    chk("new eol line 0", act_pack(), exp_pack(1, 0, 1, 0, 1, 6, 0));

    // Invalid word while running.
    go_to(160);
    set_cfg(10, 4, 4, 2, 6, 1, 1, 1, 1'b1, 1'b1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("run reject cfg_err", 32'(cfg_err), 32'd1);
    chk("run reject cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    chk("run reject pulse ends", 32'(cfg_err), 32'd0);
    go_to(168);
    chk("timing kept after reject", act_pack(), exp_pack(1, 0, 1, 0, 1, 6, 1));

    // Frame counter wrap at 2 bits.
    go_to(191);
    chk("frame_count 2", 32'(frame_count), 32'd2);
    go_to(192);
    chk("frame_count 3", 32'(frame_count), 32'd3);
    go_to(264);
    chk("frame_count wraps to 0", 32'(frame_count), 32'd0);
    go_to(336);
    chk("frame_count 1 after wrap", 32'(frame_count), 32'd1);

    // Reset mid-line aborts at once.
    go_to(340);
    reset = 1'b1;
    tick();
    chk("mid-line reset outputs", act_pack(), exp_pack(0, 0, 0, 0, 0, 0, 0));
    chk("mid-line reset running", 32'(running), 32'd0);
    chk("mid-line reset frame_count", 32'(frame_count), 32'd0);
    chk("mid-line reset cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
